// File: rtl/femto_cache_pkg.sv
// femto_cache_pkg: shared definitions for the flash instruction cache.
//   state_t : cache controller FSM states.
//   idx_w   : index width for a given number of lines.
//   tag_w   : tag width for a given word-address width and line count.
package femto_cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_REQ,
        S_WAIT
    } state_t;

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
        return addr_w - $clog2(lines);
    endfunction

endpackage

// File: rtl/flash_icache_store.sv
// flash_icache_store: valid/tag/data arrays of the direct-mapped cache.
//   clk, rst          : clock, synchronous active-high reset (clears everything)
//   i_clear           : clears all valid bits at the next edge
//   i_we, i_widx      : write enable / line index of the write port
//   i_wtag, i_wdata   : tag and data written
//   i_wvalid          : set the valid bit of the written line
//   i_ridx            : asynchronous read index
//   o_rvalid, o_rtag, o_rdata : contents of line i_ridx
module flash_icache_store
    import femto_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_we,
    input  logic             i_wvalid,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [TAG_W-1:0] i_wtag,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output logic             o_rvalid,
    output logic [TAG_W-1:0] o_rtag,
    output logic [31:0]      o_rdata
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_clear)
                r_valid <= '0;
            if (i_we) begin
                r_tag[i_widx]  <= i_wtag;
                r_data[i_widx] <= i_wdata;
                if (i_wvalid)
                    r_valid[i_widx] <= 1'b1;
            end
        end
    end

    assign o_rvalid = r_valid[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rdata  = r_data[i_ridx];

endmodule

// File: rtl/flash_icache.sv
// flash_icache: direct-mapped one-word-line read cache in front of MappedSPIFlash.
//   clk, rst                    : clock, synchronous active-high reset
//   rstrb, word_address         : CPU read request (address valid in strobe cycle)
//   rdata, rbusy                : CPU read data and stall
//   invalidate                  : clears all valid bits
//   flash_rstrb, flash_word_address : read request to the flash controller
//   flash_rdata, flash_rbusy    : flash controller response
module flash_icache
    import femto_cache_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstrb,
    input  logic [ADDR_W-1:0] word_address,
    output logic [31:0]       rdata,
    output logic              rbusy,
    input  logic              invalidate,
    output logic              flash_rstrb,
    output logic [ADDR_W-1:0] flash_word_address,
    input  logic [31:0]       flash_rdata,
    input  logic              flash_rbusy
);

    localparam int unsigned IDX_W = idx_w(LINES);
    localparam int unsigned TAG_W = tag_w(ADDR_W, LINES);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_faddr;
    logic                r_inv_pend;

    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_line_valid;
    logic [TAG_W-1:0]    w_line_tag;
    logic [31:0]         w_line_data;
    logic                w_hit;
    logic                w_capture;

    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_tag     = r_addr[ADDR_W-1:IDX_W];
    assign w_hit     = w_line_valid && (w_line_tag == w_tag);
    assign w_capture = (r_state == S_WAIT) && !flash_rbusy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (rstrb) w_next = S_LOOKUP;
            S_LOOKUP: w_next = w_hit ? S_IDLE : S_REQ;
            S_REQ:    w_next = S_WAIT;
            S_WAIT:   if (!flash_rbusy) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_faddr    <= '0;
            r_inv_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && rstrb)
                r_addr <= word_address;
            if (r_state == S_LOOKUP && !w_hit)
                r_faddr <= r_addr;
            // An invalidate seen while a request is in progress must keep the
            // eventual fill from marking its line valid.
            if (w_next == S_IDLE)
                r_inv_pend <= 1'b0;
            else if (invalidate && r_state != S_IDLE)
                r_inv_pend <= 1'b1;
        end
    end

    flash_icache_store #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (invalidate),
        .i_we     (w_capture),
        .i_wvalid (!(invalidate || r_inv_pend)),
        .i_widx   (w_idx),
        .i_wtag   (w_tag),
        .i_wdata  (flash_rdata),
        .i_ridx   (w_idx),
        .o_rvalid (w_line_valid),
        .o_rtag   (w_line_tag),
        .o_rdata  (w_line_data)
    );

    assign rdata              = w_line_data;
    assign rbusy              = (r_state == S_LOOKUP && !w_hit) || (r_state == S_REQ) || (r_state == S_WAIT);
    assign flash_rstrb        = (r_state == S_REQ);
    assign flash_word_address = r_faddr;

endmodule

// File: tb/tb_flash_icache.sv
// tb_flash_icache: randomized self-checking bench for flash_icache with a
// line-address reference model and a fixed/variable-latency flash model.
module tb_flash_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rstrb = 1'b0;
    logic [19:0] word_address = '0;
    logic [31:0] rdata;
    logic        rbusy;
    logic        invalidate = 1'b0;
    logic        flash_rstrb;
    logic [19:0] flash_word_address;
    logic [31:0] flash_rdata;
    logic        flash_rbusy;

    int n_tests = 0;
    int n_fail  = 0;
    int F       = 4;

    // flash model: returns {12'hF1A, addr}, first not-busy cycle F cycles after strobe
    int          fl_cnt = 0;
    logic [19:0] fl_addr = '0;

    always @(posedge clk) begin
        if (rst) begin
            fl_cnt <= 0;
        end else if (flash_rstrb) begin
            fl_cnt  <= F - 1;
            fl_addr <= flash_word_address;
        end else if (fl_cnt != 0) begin
            fl_cnt <= fl_cnt - 1;
        end
    end

    assign flash_rbusy = (fl_cnt != 0);
    assign flash_rdata = {12'hF1A, fl_addr};

    always #5 clk = ~clk;

    flash_icache #(
        .LINES  (16),
        .ADDR_W (20)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rstrb              (rstrb),
        .word_address       (word_address),
        .rdata              (rdata),
        .rbusy              (rbusy),
        .invalidate         (invalidate),
        .flash_rstrb        (flash_rstrb),
        .flash_word_address (flash_word_address),
        .flash_rdata        (flash_rdata),
        .flash_rbusy        (flash_rbusy)
    );

    // reference model: which address each line holds and whether it is valid
    bit          m_valid [16];
    logic [19:0] m_addr  [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear_valid();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU read; inv_at >= 1 pulses invalidate in that cycle after the strobe.
    task automatic cpu_read(input logic [19:0] a, input int inv_at, input string nm);
        int          idx;
        bit          exp_hit;
        int          exp_end;
        int          c;
        int          n_str;
        int          str_cyc;
        logic [19:0] str_addr;
        bit          done;
        bit          inv_seen;
        idx      = int'(a[3:0]);
        exp_hit  = m_valid[idx] && (m_addr[idx] == a);
        exp_end  = exp_hit ? 1 : F + 3;
        c        = 0;
        n_str    = 0;
        str_cyc  = -1;
        str_addr = '0;
        done     = 1'b0;
        inv_seen = 1'b0;
        @(negedge clk);
        rstrb        = 1'b1;
        word_address = a;
        invalidate   = 1'b0;
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            rstrb        = 1'b0;
            word_address = 20'($urandom);
            invalidate   = (c == inv_at);
            if (c == inv_at) inv_seen = 1'b1;
            if (flash_rstrb) begin
                n_str++;
                str_cyc  = c;
                str_addr = flash_word_address;
            end
            if (!rbusy) done = 1'b1;
        end
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".lat"}, 32'(c), 32'(exp_end));
        check({nm, ".rdata"}, rdata, {12'hF1A, a});
        check({nm, ".nstrobe"}, 32'(n_str), exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit && n_str == 1) begin
            check({nm, ".strobe_cyc"}, 32'(str_cyc), 32'd2);
            check({nm, ".faddr"}, 32'(str_addr), 32'(a));
        end
        if (inv_seen) model_clear_valid();
        if (!exp_hit) begin
            m_addr[idx]  = a;
            m_valid[idx] = !inv_seen;
        end
    endtask

    task automatic pulse_invalidate();
        @(negedge clk);
        rstrb      = 1'b0;
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        model_clear_valid();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstrb      = 1'b0;
            invalidate = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.rdata", rdata, 32'h0);
        check("rst.rbusy", 32'(rbusy), 32'd0);
        check("rst.flash_rstrb", 32'(flash_rstrb), 32'd0);
        check("rst.faddr", 32'(flash_word_address), 32'h0);
        rst = 1'b0;

        // directed cases, F = 4
        F = 4;
        cpu_read(20'h00010, -1, "cold_miss");
        cpu_read(20'h00010, -1, "hit");
        cpu_read(20'h00020, -1, "conflict");
        cpu_read(20'h00010, -1, "conflict_back");
        cpu_read(20'h00003, -1, "inv_fill");
        cpu_read(20'h00003, -1, "inv_hit");
        pulse_invalidate();
        cpu_read(20'h00003, -1, "inv_reread");
        cpu_read(20'h00005, 3, "inv_wait");
        cpu_read(20'h00005, -1, "inv_wait_reread");

        // F = 1: flash already ready in the first WAIT cycle
        F = 1;
        cpu_read(20'h00047, -1, "f1_miss");
        cpu_read(20'h00047, -1, "f1_hit");
        F = 4;

        // reset in cycle 4 of a miss on 0x00009
        @(negedge clk);
        rstrb        = 1'b1;
        word_address = 20'h00009;
        invalidate   = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            rstrb = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.rbusy", 32'(rbusy), 32'd0);
        check("rstmid.flash_rstrb", 32'(flash_rstrb), 32'd0);
        check("rstmid.rdata", rdata, 32'h0);
        rst = 1'b0;
        model_clear_valid();
        for (int i = 0; i < 16; i++) m_addr[i] = '0;
        cpu_read(20'h00009, -1, "rstmid_reread");
        cpu_read(20'h00010, -1, "rstmid_other");

        // randomized traffic over a small address pool to mix hits and misses
        for (int n = 0; n < 200; n++) begin
            logic [19:0] a;
            int          inv;
            a   = 20'({$urandom_range(0, 2), 4'($urandom_range(0, 15))});
            F   = $urandom_range(1, 6);
            inv = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : -1;
            cpu_read(a, inv, "rand");
            if ($urandom_range(0, 19) == 0) pulse_invalidate();
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
